// File: rtl/combat_pkg.sv
// Shared types and widths for the per-player saber combat logic.
package combat_pkg;

    localparam int unsigned X_W      = 12;
    localparam int unsigned Y_W      = 11;
    localparam int unsigned HEALTH_W = 3;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ATTACK = 2'd1,
        BLOCK  = 2'd2,
        STRIKE = 2'd3
    } saber_state_t;

endpackage

// File: rtl/manhattan_dist.sv
// Combinational |dx|+|dy| between two screen points; 13-bit result cannot overflow.
module manhattan_dist
    import combat_pkg::*;
(
    input  logic [X_W-1:0] i_ax,
    input  logic [Y_W-1:0] i_ay,
    input  logic [X_W-1:0] i_bx,
    input  logic [Y_W-1:0] i_by,
    output logic [X_W:0]   o_dist
);

    logic [X_W-1:0] w_dx;
    logic [Y_W-1:0] w_dy;

    assign w_dx   = (i_ax >= i_bx) ? (i_ax - i_bx) : (i_bx - i_ax);
    assign w_dy   = (i_ay >= i_by) ? (i_ay - i_by) : (i_by - i_ay);
    assign o_dist = {1'b0, w_dx} + {2'b00, w_dy};

endmodule

// File: rtl/saber_combat_fsm.sv
// Per-player combat FSM: once per frame turns the saber centroid into saber state,
// attack-line origin, health and hit/blocked pulses for the display stage.
module saber_combat_fsm
    import combat_pkg::*;
#(
    parameter int unsigned SPEED_THRESH      = 24,
    parameter int unsigned ATTACK_MIN_FRAMES = 3,
    parameter int unsigned COOLDOWN_FRAMES   = 30,
    parameter int unsigned MAX_HEALTH        = 5
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                nf_in,
    input  logic                game_active_in,
    input  logic                saber_valid_in,
    input  logic [X_W-1:0]      saber_x_in,
    input  logic [Y_W-1:0]      saber_y_in,
    input  logic                block_in,
    input  logic [X_W-1:0]      opp_box_x_in,
    input  logic [Y_W-1:0]      opp_box_y_in,
    input  logic [X_W-1:0]      opp_box_xmax_in,
    input  logic [Y_W-1:0]      opp_box_ymax_in,
    input  logic [1:0]          opp_saber_state_in,
    input  logic                hit_in,
    output logic [1:0]          saber_state_out,
    output logic [X_W-1:0]      attack_x_out,
    output logic [Y_W-1:0]      attack_y_out,
    output logic [HEALTH_W-1:0] health_out,
    output logic                hit_out,
    output logic                blocked_out,
    output logic                dead_out
);

    saber_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [X_W-1:0]      r_prev_x, w_prev_x_nxt, r_attack_x, w_attack_x_nxt;
    logic [Y_W-1:0]      r_prev_y, w_prev_y_nxt, r_attack_y, w_attack_y_nxt;
    logic                r_first, w_first_nxt;
    logic [HEALTH_W-1:0] r_health, w_health_nxt;
    logic                r_hit, w_hit_nxt, r_blocked, w_blocked_nxt, r_dead;
    logic [X_W:0]        w_dist, w_speed;
    logic                w_in_box, w_fast;

    manhattan_dist u_dist (
        .i_ax   (saber_x_in),
        .i_ay   (saber_y_in),
        .i_bx   (r_prev_x),
        .i_by   (r_prev_y),
        .o_dist (w_dist)
    );

    // The first frame after reset or game start has no valid predecessor.
    assign w_speed   = r_first ? '0 : w_dist;
    assign w_fast    = (w_speed >= (X_W+1)'(SPEED_THRESH));
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_in_box  = (saber_x_in >= opp_box_x_in) && (saber_x_in <= opp_box_xmax_in) &&
                       (saber_y_in >= opp_box_y_in) && (saber_y_in <= opp_box_ymax_in);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_prev_x_nxt   = r_prev_x;
        w_prev_y_nxt   = r_prev_y;
        w_first_nxt    = r_first;
        w_attack_x_nxt = r_attack_x;
        w_attack_y_nxt = r_attack_y;
        w_hit_nxt      = 1'b0;
        w_blocked_nxt  = 1'b0;

        if (nf_in && saber_valid_in) begin
            w_prev_x_nxt = saber_x_in;
            w_prev_y_nxt = saber_y_in;
            w_first_nxt  = 1'b0;
        end

        if (!game_active_in) begin
            w_state_nxt    = IDLE;
            w_cnt_nxt      = '0;
            w_first_nxt    = 1'b1;
            w_attack_x_nxt = w_prev_x_nxt;
            w_attack_y_nxt = w_prev_y_nxt;
        end else if (nf_in) begin
            if (r_dead) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else if (!saber_valid_in) begin
                // Only the block button survives a lost centroid.
                if (r_state == IDLE && block_in) begin
                    w_state_nxt = BLOCK;
                end else if (r_state == BLOCK && !block_in) begin
                    w_state_nxt = IDLE;
                end
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (block_in) begin
                            w_state_nxt = BLOCK;
                        end else if (w_fast) begin
                            w_state_nxt    = ATTACK;
                            w_attack_x_nxt = r_prev_x;
                            w_attack_y_nxt = r_prev_y;
                            w_cnt_nxt      = CNT_W'(1);
                        end
                    end
                    ATTACK: begin
                        if (!w_fast) begin
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
                        end else if (w_cnt_inc >= CNT_W'(ATTACK_MIN_FRAMES) && w_in_box) begin
                            w_state_nxt   = STRIKE;
                            w_cnt_nxt     = '0;
                            w_hit_nxt     = (opp_saber_state_in != BLOCK);
                            w_blocked_nxt = (opp_saber_state_in == BLOCK);
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                    BLOCK: begin
                        if (!block_in) begin
                            w_state_nxt = IDLE;
                        end
                    end
                    STRIKE: begin
                        if (w_cnt_inc == CNT_W'(COOLDOWN_FRAMES)) begin
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Damage uses the registered state, so a frame entering BLOCK still takes the hit.
    always_comb begin
        w_health_nxt = r_health;
        if (!game_active_in) begin
            w_health_nxt = HEALTH_W'(MAX_HEALTH);
        end else if (hit_in && r_state != BLOCK && r_health != '0) begin
            w_health_nxt = r_health - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_prev_x   <= '0;
            r_prev_y   <= '0;
            r_first    <= 1'b1;
            r_attack_x <= '0;
            r_attack_y <= '0;
            r_health   <= HEALTH_W'(MAX_HEALTH);
            r_hit      <= 1'b0;
            r_blocked  <= 1'b0;
            r_dead     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_prev_x   <= w_prev_x_nxt;
            r_prev_y   <= w_prev_y_nxt;
            r_first    <= w_first_nxt;
            r_attack_x <= w_attack_x_nxt;
            r_attack_y <= w_attack_y_nxt;
            r_health   <= w_health_nxt;
            r_hit      <= w_hit_nxt;
            r_blocked  <= w_blocked_nxt;
            r_dead     <= (w_health_nxt == '0);
        end
    end

    assign saber_state_out = r_state;
    assign attack_x_out    = r_attack_x;
    assign attack_y_out    = r_attack_y;
    assign health_out      = r_health;
    assign hit_out         = r_hit;
    assign blocked_out     = r_blocked;
    assign dead_out        = r_dead;

endmodule

// File: tb/tb_saber_combat_fsm.sv
// Table-driven bench for saber_combat_fsm with a queue of expected per-cycle outputs.
module tb_saber_combat_fsm;
    import combat_pkg::*;

    logic        clk, rst_n, nf, ga, valid, blk, hit_i;
    logic [11:0] sx;
    logic [10:0] sy;
    logic [1:0]  opp;
    logic [1:0]  st;
    logic [11:0] ax;
    logic [10:0] ay;
    logic [2:0]  hp;
    logic        hit_o, blkd_o, dead_o;

    int errors = 0;
    int checks = 0;

    saber_combat_fsm dut (
        .clk_in             (clk),
        .rst_in             (rst_n),
        .nf_in              (nf),
        .game_active_in     (ga),
        .saber_valid_in     (valid),
        .saber_x_in         (sx),
        .saber_y_in         (sy),
        .block_in           (blk),
        .opp_box_x_in       (12'd300),
        .opp_box_y_in       (11'd200),
        .opp_box_xmax_in    (12'd400),
        .opp_box_ymax_in    (11'd300),
        .opp_saber_state_in (opp),
        .hit_in             (hit_i),
        .saber_state_out    (st),
        .attack_x_out       (ax),
        .attack_y_out       (ay),
        .health_out         (hp),
        .hit_out            (hit_o),
        .blocked_out        (blkd_o),
        .dead_out           (dead_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        nf, ga, valid;
        logic [11:0] x;
        logic [10:0] y;
        logic        blk, hit;
        logic [1:0]  opp;
        logic [1:0]  e_st;
        logic        e_hit, e_blkd;
        logic [2:0]  e_hp;
        logic        chk_a;
        logic [11:0] e_ax;
        logic [10:0] e_ay;
    } vec_t;

    typedef struct {
        logic [1:0]  st;
        logic        hit, blkd, dead;
        logic [2:0]  hp;
        logic        chk_a;
        logic [11:0] ax;
        logic [10:0] ay;
        int          tag;
    } exp_t;

    exp_t  sb[$];
    vec_t  vecs[0:38];

    function automatic vec_t mk(input logic n, input logic g, input logic v, input int x,
                                input int y, input logic b, input logic h, input logic [1:0] o,
                                input logic [1:0] es, input logic eh, input logic eb,
                                input int ehp, input logic ca, input int eax, input int eay);
        vec_t r;
        r.nf = n; r.ga = g; r.valid = v; r.x = 12'(x); r.y = 11'(y); r.blk = b; r.hit = h;
        r.opp = o; r.e_st = es; r.e_hit = eh; r.e_blkd = eb; r.e_hp = 3'(ehp);
        r.chk_a = ca; r.e_ax = 12'(eax); r.e_ay = 11'(eay);
        return r;
    endfunction

    task automatic cmp(input string nm, input int tag, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", nm, tag, act, req);
        end
    endtask

    task automatic apply(input vec_t v, input int tag);
        exp_t e;
        nf = v.nf; ga = v.ga; valid = v.valid; sx = v.x; sy = v.y;
        blk = v.blk; hit_i = v.hit; opp = v.opp;
        e.st = v.e_st; e.hit = v.e_hit; e.blkd = v.e_blkd; e.hp = v.e_hp;
        e.dead = (v.e_hp == 3'd0); e.chk_a = v.chk_a; e.ax = v.e_ax; e.ay = v.e_ay; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        nf = 1'b0; hit_i = 1'b0;
        e = sb.pop_front();
        cmp("state", e.tag, int'(st), int'(e.st));
        cmp("hit_out", e.tag, int'(hit_o), int'(e.hit));
        cmp("blocked_out", e.tag, int'(blkd_o), int'(e.blkd));
        cmp("health", e.tag, int'(hp), int'(e.hp));
        cmp("dead", e.tag, int'(dead_o), int'(e.dead));
        if (e.chk_a) begin
            cmp("attack_x", e.tag, int'(ax), int'(e.ax));
            cmp("attack_y", e.tag, int'(ay), int'(e.ay));
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply(vecs[i], i);
    endtask

    // 29 frames held in STRIKE, IDLE on the 30th.
    task automatic cooldown(input logic [1:0] o, input int base);
        for (int k = 1; k <= 30; k++) begin
            apply(mk(1, 1, 1, 300, 250, 0, 0, o, (k == 30) ? IDLE : STRIKE, 0, 0, 5, 0, 0, 0),
                  base + k);
        end
    endtask

    task automatic check_reset(input int tag);
        cmp("rst_state", tag, int'(st), 0);
        cmp("rst_attack_x", tag, int'(ax), 0);
        cmp("rst_attack_y", tag, int'(ay), 0);
        cmp("rst_health", tag, int'(hp), 5);
        cmp("rst_hit", tag, int'(hit_o), 0);
        cmp("rst_blocked", tag, int'(blkd_o), 0);
        cmp("rst_dead", tag, int'(dead_o), 0);
    endtask

    initial begin
        // Swing without strike
        vecs[0]  = mk(1, 1, 1, 100, 100, 0, 0, 0, IDLE,   0, 0, 5, 1, 0, 0);
        vecs[1]  = mk(1, 1, 1, 130, 100, 0, 0, 0, ATTACK, 0, 0, 5, 1, 100, 100);
        vecs[2]  = mk(1, 1, 1, 130, 100, 0, 0, 0, IDLE,   0, 0, 5, 1, 100, 100);
        // Landed strike
        vecs[3]  = mk(1, 0, 1, 180, 250, 0, 0, 0, IDLE,   0, 0, 5, 1, 180, 250);
        vecs[4]  = mk(1, 1, 1, 180, 250, 0, 0, 0, IDLE,   0, 0, 5, 1, 180, 250);
        vecs[5]  = mk(1, 1, 1, 220, 250, 0, 0, 0, ATTACK, 0, 0, 5, 1, 180, 250);
        vecs[6]  = mk(1, 1, 1, 260, 250, 0, 0, 0, ATTACK, 0, 0, 5, 1, 180, 250);
        vecs[7]  = mk(1, 1, 1, 300, 250, 0, 0, 0, STRIKE, 1, 0, 5, 1, 180, 250);
        vecs[8]  = mk(0, 1, 1, 300, 250, 0, 0, 0, STRIKE, 0, 0, 5, 1, 180, 250);
        // Blocked strike
        vecs[9]  = mk(1, 0, 1, 180, 250, 0, 0, 2, IDLE,   0, 0, 5, 1, 180, 250);
        vecs[10] = mk(1, 1, 1, 180, 250, 0, 0, 2, IDLE,   0, 0, 5, 0, 0, 0);
        vecs[11] = mk(1, 1, 1, 220, 250, 0, 0, 2, ATTACK, 0, 0, 5, 0, 0, 0);
        vecs[12] = mk(1, 1, 1, 260, 250, 0, 0, 2, ATTACK, 0, 0, 5, 0, 0, 0);
        vecs[13] = mk(1, 1, 1, 300, 250, 0, 0, 2, STRIKE, 0, 1, 5, 0, 0, 0);
        vecs[14] = mk(0, 1, 1, 300, 250, 0, 0, 2, STRIKE, 0, 0, 5, 0, 0, 0);
        // Invalid frame mid-ATTACK freezes the counter and prev
        vecs[15] = mk(1, 0, 1, 100, 100, 0, 0, 0, IDLE,   0, 0, 5, 1, 100, 100);
        vecs[16] = mk(1, 1, 1, 100, 100, 0, 0, 0, IDLE,   0, 0, 5, 0, 0, 0);
        vecs[17] = mk(1, 1, 1, 130, 100, 0, 0, 0, ATTACK, 0, 0, 5, 1, 100, 100);
        vecs[18] = mk(1, 1, 0, 500, 500, 0, 0, 0, ATTACK, 0, 0, 5, 1, 100, 100);
        vecs[19] = mk(1, 1, 1, 300, 250, 0, 0, 0, ATTACK, 0, 0, 5, 1, 100, 100);
        vecs[20] = mk(1, 1, 1, 340, 250, 0, 0, 0, STRIKE, 1, 0, 5, 1, 100, 100);
        // Health after reset: six hits in IDLE
        vecs[21] = mk(0, 1, 0, 0, 0, 0, 1, 0, IDLE, 0, 0, 4, 0, 0, 0);
        vecs[22] = mk(0, 1, 0, 0, 0, 0, 1, 0, IDLE, 0, 0, 3, 0, 0, 0);
        vecs[23] = mk(0, 1, 0, 0, 0, 0, 1, 0, IDLE, 0, 0, 2, 0, 0, 0);
        vecs[24] = mk(0, 1, 0, 0, 0, 0, 1, 0, IDLE, 0, 0, 1, 0, 0, 0);
        vecs[25] = mk(0, 1, 0, 0, 0, 0, 1, 0, IDLE, 0, 0, 0, 0, 0, 0);
        vecs[26] = mk(0, 1, 0, 0, 0, 0, 1, 0, IDLE, 0, 0, 0, 0, 0, 0);
        vecs[27] = mk(1, 1, 1, 100, 100, 0, 0, 0, IDLE, 0, 0, 0, 0, 0, 0);
        vecs[28] = mk(1, 1, 1, 200, 100, 0, 0, 0, IDLE, 0, 0, 0, 0, 0, 0);
        vecs[29] = mk(1, 1, 1, 200, 100, 1, 0, 0, IDLE, 0, 0, 0, 0, 0, 0);
        // Block behaviour, then game drop mid-ATTACK
        vecs[30] = mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE,   0, 0, 5, 1, 200, 100);
        vecs[31] = mk(1, 1, 1, 100, 100, 1, 0, 0, BLOCK, 0, 0, 5, 0, 0, 0);
        vecs[32] = mk(0, 1, 0, 0, 0, 1, 1, 0, BLOCK,   0, 0, 5, 0, 0, 0);
        vecs[33] = mk(1, 1, 1, 100, 100, 0, 0, 0, IDLE, 0, 0, 5, 0, 0, 0);
        vecs[34] = mk(1, 1, 1, 200, 100, 1, 1, 0, BLOCK, 0, 0, 4, 0, 0, 0);
        vecs[35] = mk(1, 1, 0, 500, 500, 1, 0, 0, BLOCK, 0, 0, 4, 0, 0, 0);
        vecs[36] = mk(1, 1, 0, 500, 500, 0, 0, 0, IDLE,  0, 0, 4, 0, 0, 0);
        vecs[37] = mk(1, 1, 1, 300, 100, 0, 0, 0, ATTACK, 0, 0, 4, 1, 200, 100);
        vecs[38] = mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE,   0, 0, 5, 1, 300, 100);

        rst_n = 1'b0; nf = 1'b0; ga = 1'b0; valid = 1'b0; sx = '0; sy = '0;
        blk = 1'b0; hit_i = 1'b0; opp = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset(-1);
        rst_n = 1'b1;
        ga = 1'b1;

        run_rows(0, 8);
        cooldown(2'd0, 100);
        run_rows(9, 14);
        cooldown(2'd2, 200);
        run_rows(15, 20);

        // Reset while in STRIKE, with a frame pulse present
        rst_n = 1'b0; nf = 1'b1; valid = 1'b1; sx = 12'd350; sy = 11'd250;
        @(posedge clk);
        #1;
        nf = 1'b0;
        check_reset(-2);
        rst_n = 1'b1;

        run_rows(21, 38);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
